// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_params (package)
// Description : 640x480 @ 60 Hz raster constants shared by the timing
//               generator, the text/title overlay and the sprite renderers.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_params;

  // Coordinate width; no counter value ever reaches 1024.
  localparam int COORD_W = 10;

  // Horizontal segments, in pixels.
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  // Vertical segments, in lines.
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  // Derived values; sync windows are inclusive on both ends.
  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;

  // True when a coordinate lies inside the inclusive window [lo, hi].
  function automatic logic in_range(coord_t val, int lo, int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Raster timing bundle: coordinates, qualifiers, sync and
//               pixel/line/frame strobes. The timing generator drives the
//               master side; pixel-domain consumers take the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  import vga_params::*;

  coord_t pos_x;
  coord_t pos_y;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   pixel_tick;
  logic   line_start;
  logic   frame_start;

  modport master (
    output pos_x, pos_y, video_on, hsync, vsync,
           pixel_tick, line_start, frame_start
  );

  modport slave (
    input  pos_x, pos_y, video_on, hsync, vsync,
           pixel_tick, line_start, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/vga_timing_gen_tick.sv
`default_nettype none
// ============================================================================
// Module      : pixel_tick_gen
// Description : Divides the system clock into a one-clk pixel enable that
//               fires every CLK_DIV clocks. The first clock after reset is
//               a start cycle so the divider begins phase 0 in step with the
//               coordinate (0,0) presented by the timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  wire  clk,
  input  wire  reset,
  output logic tick
);

  logic r_run;

  // Run flag: low in reset, high from the first clock after release.
  always_ff @(posedge clk) begin
    if (reset) r_run <= 1'b0;
    else       r_run <= 1'b1;
  end

  generate
    if (CLK_DIV == 1) begin : g_div_one
      // Every clock is a pixel once running.
      assign tick = r_run;
    end else begin : g_div_n
      localparam int              DIV_W   = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] r_div;

      // Divider phase: held at 0 through the start cycle, then wraps at DIV_MAX.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_div <= '0;
        end else if (r_run) begin
          r_div <= (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
        end
      end

      assign tick = r_run && (r_div == DIV_MAX);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480 @ 60 Hz raster timing. Horizontal/vertical counters
//               advance on the pixel enable; video_on, hsync and vsync are
//               decoded from the next-state coordinates and registered so
//               they line up with pos_x/pos_y on the same clock.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_params::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = vga_params::H_DISPLAY,
  parameter int H_FRONT   = vga_params::H_FRONT,
  parameter int H_SYNC    = vga_params::H_SYNC,
  parameter int H_BACK    = vga_params::H_BACK,
  parameter int V_DISPLAY = vga_params::V_DISPLAY,
  parameter int V_FRONT   = vga_params::V_FRONT,
  parameter int V_SYNC    = vga_params::V_SYNC,
  parameter int V_BACK    = vga_params::V_BACK
) (
  input  wire              clk,
  input  wire              reset,
  vga_timing_gen_if.master vga
);

  // Geometry for this instance, all in coordinate width where compared.
  localparam coord_t H_LAST   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_ACT    = coord_t'(H_DISPLAY);
  localparam coord_t V_ACT    = coord_t'(V_DISPLAY);
  localparam int     HS_START = H_DISPLAY + H_FRONT;
  localparam int     HS_END   = HS_START + H_SYNC - 1;
  localparam int     VS_START = V_DISPLAY + V_FRONT;
  localparam int     VS_END   = VS_START + V_SYNC - 1;

  logic   w_tick;
  logic   w_h_wrap;
  logic   w_v_wrap;
  coord_t w_h_next;
  coord_t w_v_next;

  coord_t r_h;
  coord_t r_v;
  logic   r_video_on;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_line_start;
  logic   r_frame_start;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Next-state coordinates: advance on the pixel enable, wrap line then frame.
  always_comb begin
    w_h_wrap = w_tick && (r_h == H_LAST);
    w_v_wrap = w_h_wrap && (r_v == V_LAST);
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_tick) begin
      w_h_next = w_h_wrap ? '0 : r_h + 1'b1;
    end
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? '0 : r_v + 1'b1;
    end
  end

  // Counters and registered decodes; qualifiers use the next coordinates so
  // they appear on the same clock as the coordinates they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h           <= '0;
      r_v           <= '0;
      r_video_on    <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_video_on    <= (w_h_next < H_ACT) && (w_v_next < V_ACT);
      r_hsync       <= !in_range(w_h_next, HS_START, HS_END);
      r_vsync       <= !in_range(w_v_next, VS_START, VS_END);
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
    end
  end

  assign vga.pos_x       = r_h;
  assign vga.pos_y       = r_v;
  assign vga.video_on    = r_video_on;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.pixel_tick  = w_tick;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed bench. Instance A uses the full 640x480 geometry
//               with CLK_DIV=2; instances B (CLK_DIV=2) and C (CLK_DIV=1)
//               use a reduced 32x19 raster so whole frames fit a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen #(.CLK_DIV(2)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (if_a)
  );

  // Small raster: H 16+4+8+4 = 32 (hsync low 20..27), V 12+2+2+3 = 19 (vsync low 14..15).
  vga_timing_gen #(
    .CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (if_b)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_c (
    .clk   (clk),
    .reset (rst_c),
    .vga   (if_c)
  );

  // Status word per instance: {x[25:16], y[15:6], video_on, hsync, vsync, tick, line_start, frame_start}
  logic [25:0] st [3];
  assign st[0] = {if_a.pos_x, if_a.pos_y, if_a.video_on, if_a.hsync, if_a.vsync,
                  if_a.pixel_tick, if_a.line_start, if_a.frame_start};
  assign st[1] = {if_b.pos_x, if_b.pos_y, if_b.video_on, if_b.hsync, if_b.vsync,
                  if_b.pixel_tick, if_b.line_start, if_b.frame_start};
  assign st[2] = {if_c.pos_x, if_c.pos_y, if_c.video_on, if_c.hsync, if_c.vsync,
                  if_c.pixel_tick, if_c.line_start, if_c.frame_start};

  localparam logic [25:0] RST_ST = {10'd0, 10'd0, 6'b011000};

  function automatic logic [25:0] mk(int x, int y, bit vo, bit hs, bit vs,
                                     bit tk, bit ls, bit fs);
    return {10'(x), 10'(y), vo, hs, vs, tk, ls, fs};
  endfunction

  task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Advance until instance d shows (x,y) with the given tick level, bounded.
  task automatic wait_pix(input int d, input int x, input int y, input bit tk,
                          input int budget, input string tag);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit = (st[d][25:16] == 10'(x)) && (st[d][15:6] == 10'(y)) && (st[d][2] == tk);
    end
    chk_int(tag, int'(hit), 1);
  endtask

  initial begin
    int n;
    int vs_low;
    int vs_bad;
    int ls_cnt;
    int tk_low;
    bit seen;

    // ---------------- reset held 5 clks ----------------
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_hold_a", st[0], RST_ST);
    end
    chk("reset_hold_b", st[1], RST_ST);
    chk("reset_hold_c", st[2], RST_ST);

    // ---------------- release A, first clocks ----------------
    rst_a = 1'b0;
    step(); chk("a_first_clk",  st[0], mk(0, 0, 1, 1, 1, 0, 0, 0));
    step(); chk("a_tick_1",     st[0], mk(0, 0, 1, 1, 1, 1, 0, 0));
    step(); chk("a_tick_0",     st[0], mk(1, 0, 1, 1, 1, 0, 0, 0));
    step(); chk("a_tick_1b",    st[0], mk(1, 0, 1, 1, 1, 1, 0, 0));

    // ---------------- line wrap at y=10 ----------------
    wait_pix(0, 799, 10, 1'b1, 20000, "a_reach_799_10");
    chk("a_at_799_10", st[0], mk(799, 10, 0, 1, 1, 1, 0, 0));
    step(); chk("a_line_wrap",   st[0], mk(0, 11, 1, 1, 1, 0, 1, 0));
    step(); chk("a_line_pulse1", st[0], mk(0, 11, 1, 1, 1, 1, 0, 0));

    // ---------------- one-line sweep: video_on and hsync edges ----------------
    wait_pix(0, 639, 11, 1'b1, 2000, "a_reach_639");
    chk("a_x639", st[0], mk(639, 11, 1, 1, 1, 1, 0, 0));
    step(); chk("a_x640_video_off", st[0], mk(640, 11, 0, 1, 1, 0, 0, 0));
    wait_pix(0, 655, 11, 1'b1, 2000, "a_reach_655");
    chk("a_x655", st[0], mk(655, 11, 0, 1, 1, 1, 0, 0));
    step(); chk("a_x656_hsync_fall", st[0], mk(656, 11, 0, 0, 1, 0, 0, 0));
    wait_pix(0, 751, 11, 1'b1, 2000, "a_reach_751");
    chk("a_x751", st[0], mk(751, 11, 0, 0, 1, 1, 0, 0));
    step(); chk("a_x752_hsync_rise", st[0], mk(752, 11, 0, 1, 1, 0, 0, 0));

    // ---------------- B: frame wrap and frame length ----------------
    chk("b_still_reset", st[1], RST_ST);
    rst_b = 1'b0;
    step(); chk("b_first_clk", st[1], mk(0, 0, 1, 1, 1, 0, 0, 0));
    wait_pix(1, 31, 18, 1'b1, 3000, "b_reach_31_18");
    chk("b_at_last", st[1], mk(31, 18, 0, 1, 1, 1, 0, 0));
    step(); chk("b_frame_wrap",   st[1], mk(0, 0, 1, 1, 1, 0, 1, 1));
    step(); chk("b_frame_pulse1", st[1], mk(0, 0, 1, 1, 1, 1, 0, 0));

    n      = 1;
    vs_low = 0;
    vs_bad = 0;
    ls_cnt = 0;
    seen   = 1'b0;
    while (!seen && n < 3000) begin
      step();
      n++;
      if (st[1][3] == 1'b0) vs_low++;
      if ((st[1][3] == 1'b0) != (st[1][15:6] == 10'd14 || st[1][15:6] == 10'd15)) vs_bad++;
      if (st[1][1]) ls_cnt++;
      seen = st[1][0];
    end
    chk_int("b_frame_len",      n,      1216);
    chk_int("b_vsync_low_clks", vs_low, 128);
    chk_int("b_vsync_window",   vs_bad, 0);
    chk_int("b_line_starts",    ls_cnt, 19);

    // ---------------- B: mid-frame reset at divider phase 0 ----------------
    wait_pix(1, 10, 5, 1'b0, 3000, "b_reach_10_5");
    rst_b = 1'b1;
    step(); chk("b_mid_reset", st[1], RST_ST);
    rst_b = 1'b0;
    step(); chk("b_after_reset",  st[1], mk(0, 0, 1, 1, 1, 0, 0, 0));
    step(); chk("b_after_reset2", st[1], mk(0, 0, 1, 1, 1, 1, 0, 0));

    // ---------------- C: CLK_DIV=1 ----------------
    chk("c_still_reset", st[2], RST_ST);
    rst_c = 1'b0;
    step(); chk("c_first_clk", st[2], mk(0, 0, 1, 1, 1, 1, 0, 0));
    step(); chk("c_x1",        st[2], mk(1, 0, 1, 1, 1, 1, 0, 0));
    step(); chk("c_x2",        st[2], mk(2, 0, 1, 1, 1, 1, 0, 0));

    tk_low = 0;
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < 2000) begin
      step();
      n++;
      if (!st[2][2]) tk_low++;
      seen = st[2][0];
    end
    chk_int("c_first_frame_seen", int'(seen), 1);
    chk("c_frame_wrap", st[2], mk(0, 0, 1, 1, 1, 1, 1, 1));

    n    = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      step();
      n++;
      if (!st[2][2]) tk_low++;
      seen = st[2][0];
    end
    chk_int("c_frame_len", n,      608);
    chk_int("c_tick_low",  tk_low, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480 @ 60 Hz VGA raster timing for the Starflux display pipeline. It sits directly upstream of the text/title overlay and sprite renderers. It supplies the current pixel coordinates (`pos_x`, `pos_y`), active-video qualification, and the sync pulses the DAC/connector needs. A divided pixel enable is derived from the system clock, so every pixel-domain block runs on `clk` alone.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (50 MHz clk -> 25 MHz pixel rate); legal 1..16
- `H_DISPLAY`, 640 / `H_FRONT`, 16 / `H_SYNC`, 96 / `H_BACK`, 48: horizontal segments in pixels (total 800)
- `V_DISPLAY`, 480 / `V_FRONT`, 10 / `V_SYNC`, 2 / `V_BACK`, 33: vertical segments in lines (total 525)
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `pos_x`  out  10  horizontal counter, 0..799
- `pos_y`  out  10  vertical counter, 0..524
- `video_on`  out  1  high when `pos_x < H_DISPLAY` and `pos_y < V_DISPLAY`
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `pixel_tick`  out  1  one-clk strobe; coordinates advance on the clk edge ending this cycle
- `line_start`  out  1  one-clk pulse, first clk in which `pos_x` == 0 after a line wrap
- `frame_start`  out  1  one-clk pulse, first clk in which (`pos_x`, `pos_y`) == (0,0) after a frame wrap

## Operation
- The divider counter runs 0..`CLK_DIV`-1. `pixel_tick` is high when the divider equals `CLK_DIV`-1. With `CLK_DIV`=1, `pixel_tick` is constantly high out of reset.
- On each `pixel_tick`, h_count increments. At `H_TOTAL`-1 (799) it wraps to 0 and v_count increments. v_count at `V_TOTAL`-1 (524) wraps to 0 on the same tick.
- `pos_x`/`pos_y` are the raw h/v counters, unsigned, 10 bits. No counter value reaches 1024.
- hsync is low for `pos_x` in [`H_DISPLAY`+`H_FRONT`, `H_DISPLAY`+`H_FRONT`+`H_SYNC`-1], i.e. 656..751. It is high elsewhere.
- vsync is low for `pos_y` in [490, 491] for the full line width. It is high elsewhere.
- `video_on`, `hsync` and `vsync` are registered decodes. They are coincident with the `pos_x`/`pos_y` values on the same clk, with no skew between coordinate and qualifier.
- `line_start`/`frame_start` fire only on a wrap, never on reset release. Both are asserted in the same clk when the frame wraps.

## Timing
- Reset values (held while `reset`=1): divider 0, `pos_x` 0, `pos_y` 0, `video_on` 0, `hsync` 1, `vsync` 1, `pixel_tick` 0, `line_start` 0, `frame_start` 0.
- First clk after `reset` deasserts: `pos_x`=0, `pos_y`=0, `video_on`=1. `pixel_tick` first rises `CLK_DIV`-1 clks later.
- Each coordinate value is held for exactly `CLK_DIV` clks.
- Line period = 800·`CLK_DIV` clks. Frame period = 420000·`CLK_DIV` clks.
- Reset asserted mid-frame takes effect on the next clk edge regardless of divider phase. There is no partial-line completion.
- Downstream consumers sample on `pixel_tick` or on any clk. Font-ROM style consumers carrying one clk of read latency must delay `video_on`/sync themselves. This block adds no pipeline compensation.

## Structure
- Shared package/header `vga_params`: the 640x480 segment constants, the derived `H_TOTAL`, `V_TOTAL`, `H_SYNC_START`, `H_SYNC_END`, `V_SYNC_START` and `V_SYNC_END` values, and the coordinate width (10). The overlay and renderers use the same constants.
- One sub-module, `pixel_tick_gen`: a parameterised `CLK_DIV` enable divider with synchronous reset. The h/v counters and decode stay in the top.

## Test plan
- Reset held 5 clks, then released (`CLK_DIV`=2) -> all outputs at reset values during reset. (0,0) with `video_on`=1 on the first clk after release. `pixel_tick` toggles 0,1,0,1 from there.
- Run to `pos_x`=799, `pos_y`=10 -> next tick gives (0,11) with `line_start` high for exactly one clk and `frame_start` low.
- Sweep one line -> `hsync` falls at `pos_x`=656 and rises at 752. `video_on` falls at `pos_x`=640.
- Run to (799,524) -> next tick gives (0,0) with `line_start` and `frame_start` both high for one clk. `vsync` was low only for lines 490–491. The measured frame length is 840000 clks.
- Assert `reset` for 1 clk at (300,200) with the divider mid-phase -> next clk gives (0,0), reset outputs, and no start pulses.
- `CLK_DIV`=1 build -> `pixel_tick` constantly high, coordinates advance every clk, and the frame length is 420000 clks.
